// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N-channel lane multiplexer with manual select,
// continuous scan and single-sweep sequencing. Samples leave on a
// valid/ready handshake so a stalling consumer never loses a channel.
module mux_scan_seq #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]          sett,
  input  logic [1:0]                mode,
  input  logic                      start,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          ch,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      sweep_done
);

  localparam int unsigned DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [DCNT_W-1:0] LAST_DW = DCNT_W'(DWELL - 1);

  localparam logic [1:0] M_MANUAL = 2'b00;
  localparam logic [1:0] M_SCAN   = 2'b01;
  localparam logic [1:0] M_SWEEP  = 2'b10;

  // Sweep sequencer states; busy is the state flop itself.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]        mode_q;

  logic [WIDTH-1:0]  y_d;
  logic [SEL_W-1:0]  ch_d;
  logic              valid_d;
  logic              done_d;

  logic              can_load;
  logic              mode_chg;
  logic              dwell_end;
  logic              manual_step;
  logic              scan_step;

  // Lane select; an index beyond the last channel yields zero.
  function automatic logic [WIDTH-1:0] pick(
    input logic [CHANNELS*WIDTH-1:0] bus,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (idx == SEL_W'(i)) begin
        r = bus[i*WIDTH +: WIDTH];
      end
    end
    return r;
  endfunction

  // Handshake and sequencing qualifiers.
  always_comb begin
    can_load  = !out_valid || out_ready;
    mode_chg  = (mode != mode_q);
    dwell_end = (dcnt_q == LAST_DW);
  end

  // Next-state and output-register computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dcnt_d      = dcnt_q;
    y_d         = y;
    ch_d        = ch;
    valid_d     = out_valid;
    done_d      = 1'b0;
    manual_step = 1'b0;
    scan_step   = 1'b0;

    // A consumed sample frees the slot unless a new one replaces it below.
    if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end

    if (mode_chg) begin
      // Any mode switch restarts sequencing and aborts a sweep silently.
      state_d     = S_IDLE;
      ptr_d       = '0;
      dcnt_d      = '0;
      manual_step = (mode == M_MANUAL);
    end else begin
      case (mode)
        M_MANUAL: manual_step = 1'b1;
        M_SCAN:   scan_step   = 1'b1;
        M_SWEEP: begin
          if (state_q == S_IDLE) begin
            if (start) begin
              state_d = S_RUN;
              ptr_d   = '0;
              dcnt_d  = '0;
            end
          end else begin
            scan_step = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (manual_step && can_load) begin
      y_d     = pick(data, sett);
      ch_d    = sett;
      valid_d = 1'b1;
    end

    if (scan_step) begin
      if (!dwell_end) begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end else if (can_load) begin
        y_d     = pick(data, ptr_q);
        ch_d    = ptr_q;
        valid_d = 1'b1;
        dcnt_d  = '0;
        ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + SEL_W'(1);
        if ((state_q == S_RUN) && (ptr_q == LAST_CH)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      // Dwell expired but stalled: dcnt and ptr hold until the slot frees.
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      dcnt_q     <= '0;
      mode_q     <= M_MANUAL;
      y          <= '0;
      ch         <= '0;
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dcnt_q     <= dcnt_d;
      mode_q     <= mode;
      y          <= y_d;
      ch         <= ch_d;
      out_valid  <= valid_d;
      sweep_done <= done_d;
    end
  end

  assign busy = state_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: two instances (8x1-bit dwell 1, 5x4-bit dwell 2)
// share stimulus; a behavioural model queues expected samples and a
// negedge monitor pops them on every handshake.
module tb_mux_scan_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [2:0]  sett;
  logic [1:0]  mode;
  logic        start;
  logic        out_ready;

  logic [0:0] y_a;
  logic [2:0] ch_a;
  logic       ov_a, busy_a, done_a;
  logic [3:0] y_b;
  logic [2:0] ch_b;
  logic       ov_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  mux_scan_seq #(.WIDTH(1), .CHANNELS(8), .SEL_W(3), .DWELL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .data(data[7:0]), .sett(sett), .mode(mode),
    .start(start), .out_ready(out_ready), .y(y_a), .ch(ch_a),
    .out_valid(ov_a), .busy(busy_a), .sweep_done(done_a)
  );

  mux_scan_seq #(.WIDTH(4), .CHANNELS(5), .SEL_W(3), .DWELL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .data(data[19:0]), .sett(sett), .mode(mode),
    .start(start), .out_ready(out_ready), .y(y_b), .ch(ch_b),
    .out_valid(ov_b), .busy(busy_b), .sweep_done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Per-instance geometry.
  function automatic int nch(input int k); return (k == 0) ? 8 : 5; endfunction
  function automatic int ndw(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int nwd(input int k); return (k == 0) ? 1 : 4; endfunction

  function automatic int chan_val(input int k, input int c);
    logic [31:0] v;
    if (c >= nch(k)) return 0;
    v = (data >> (c * nwd(k))) & ((32'd1 << nwd(k)) - 32'd1);
    return int'(v);
  endfunction

  // Reference model state: slot occupancy, next channel, cycles waited on
  // it, sweep in progress with samples left, previous mode, done pulse.
  bit       occ[2]   = '{0, 0};
  int       nxt[2]   = '{0, 0};
  int       waited[2] = '{0, 0};
  bit       swp[2]   = '{0, 0};
  int       left[2]  = '{0, 0};
  logic [1:0] pm[2]  = '{2'b00, 2'b00};
  bit       dn[2]    = '{0, 0};
  bit       stall[2] = '{0, 0};
  int       py[2]    = '{0, 0};
  int       pc[2]    = '{0, 0};
  int       q0[$];
  int       q1[$];

  function automatic void scan_tick(input int k, input bit can, output bit ld, output int lch);
    ld  = 1'b0;
    lch = 0;
    if (waited[k] < ndw(k) - 1) begin
      waited[k]++;
    end else if (can) begin
      ld        = 1'b1;
      lch       = nxt[k];
      waited[k] = 0;
      nxt[k]    = (nxt[k] + 1) % nch(k);
    end
  endfunction

  function automatic void model_step(input int k);
    bit can;
    bit ld;
    int lch;
    can   = !occ[k] || out_ready;
    ld    = 1'b0;
    lch   = 0;
    dn[k] = 1'b0;
    if (mode != pm[k]) begin
      nxt[k] = 0; waited[k] = 0; swp[k] = 1'b0;
      if (mode == 2'b00 && can) begin ld = 1'b1; lch = int'(sett); end
    end else begin
      case (mode)
        2'b00: if (can) begin ld = 1'b1; lch = int'(sett); end
        2'b01: scan_tick(k, can, ld, lch);
        2'b10: begin
          if (!swp[k]) begin
            if (start) begin swp[k] = 1'b1; nxt[k] = 0; waited[k] = 0; left[k] = nch(k); end
          end else begin
            scan_tick(k, can, ld, lch);
            if (ld) begin
              left[k]--;
              if (left[k] == 0) begin swp[k] = 1'b0; dn[k] = 1'b1; end
            end
          end
        end
        default: ;
      endcase
    end
    pm[k] = mode;
    if (ld) begin
      if (k == 0) q0.push_back(chan_val(k, lch) * 8 + lch);
      else        q1.push_back(chan_val(k, lch) * 8 + lch);
      occ[k] = 1'b1;
    end else if (occ[k] && out_ready) begin
      occ[k] = 1'b0;
    end
  endfunction

  // Reference model advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        occ[k] = 1'b0; nxt[k] = 0; waited[k] = 0; swp[k] = 1'b0;
        left[k] = 0; pm[k] = 2'b00; dn[k] = 1'b0; stall[k] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  function automatic void mon(input int k, input int yv, input int cv,
                              input bit v, input bit b, input bit d);
    int e;
    bit empty;
    chk($sformatf("out_valid%0d", k), int'(v), int'(occ[k]));
    chk($sformatf("busy%0d", k), int'(b), int'(swp[k]));
    chk($sformatf("sweep_done%0d", k), int'(d), int'(dn[k]));
    if (stall[k]) begin
      chk($sformatf("stall_y%0d", k), yv, py[k]);
      chk($sformatf("stall_ch%0d", k), cv, pc[k]);
    end
    if (v && out_ready) begin
      empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL sample%0d: got y=%0d ch=%0d expected no sample", k, yv, cv);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("y%0d", k), yv, e / 8);
        chk($sformatf("ch%0d", k), cv, e % 8);
      end
    end
    stall[k] = v && !out_ready;
    py[k] = yv;
    pc[k] = cv;
  endfunction

  // Monitor samples away from the active edge.
  always @(negedge clk) begin
    mon(0, int'(y_a), int'(ch_a), ov_a, busy_a, done_a);
    mon(1, int'(y_b), int'(ch_b), ov_b, busy_b, done_b);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_y_a"}, int'(y_a), 0);     chk({tag, "_ch_a"}, int'(ch_a), 0);
    chk({tag, "_ov_a"}, int'(ov_a), 0);   chk({tag, "_busy_a"}, int'(busy_a), 0);
    chk({tag, "_done_a"}, int'(done_a), 0);
    chk({tag, "_y_b"}, int'(y_b), 0);     chk({tag, "_ch_b"}, int'(ch_b), 0);
    chk({tag, "_ov_b"}, int'(ov_b), 0);   chk({tag, "_busy_b"}, int'(busy_b), 0);
    chk({tag, "_done_b"}, int'(done_b), 0);
  endtask

  logic [7:0] pat;
  int nb0, nb1, nd0, nd1;

  initial begin
    rst_n = 1'b0; mode = 2'b00; sett = '0; start = 1'b0; out_ready = 1'b1; data = '0;
    pat = 8'h8d;
    tick(3);
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // Manual select stepping through all channels.
    data = 32'h0000_008d;
    for (int i = 0; i < 8; i++) begin
      sett = 3'(i);
      tick(1);
      chk("manual_y", int'(y_a), int'(pat[i]));
      chk("manual_ch", int'(ch_a), i);
      tick(1);
    end

    // Continuous scan, dwell 1: one sample per cycle wrapping at 7.
    mode = 2'b01;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      chk("scan_ch", int'(ch_a), i % 8);
      chk("scan_y", int'(y_a), int'(pat[i % 8]));
      chk("scan_valid", int'(ov_a), 1);
      tick(1);
    end

    // Backpressure on the dwell-2 instance while it shows channel 3.
    for (int t = 0; t < 50 && ch_b != 3'd3; t++) tick(1);
    chk("bp_reach_ch3", int'(ch_b), 3);
    out_ready = 1'b0;
    tick(5);
    chk("bp_hold_ch", int'(ch_b), 3);
    chk("bp_hold_valid", int'(ov_b), 1);
    out_ready = 1'b1;
    for (int t = 0; t < 10 && ch_b == 3'd3; t++) tick(1);
    chk("bp_next_ch", int'(ch_b), 4);

    // Single sweep with a second start pulse mid-sweep.
    mode = 2'b10;
    tick(1);
    start = 1'b1;
    tick(1);
    nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0;
    for (int i = 0; i < 16; i++) begin
      start = (i == 3);
      if (busy_a) nb0++;
      if (busy_b) nb1++;
      if (done_a) begin nd0++; chk("sweep_done_ch_a", int'(ch_a), 7); end
      if (done_b) begin nd1++; chk("sweep_done_ch_b", int'(ch_b), 4); end
      tick(1);
    end
    start = 1'b0;
    chk("sweep_busy_cycles_a", nb0, 8);
    chk("sweep_busy_cycles_b", nb1, 10);
    chk("sweep_done_pulses_a", nd0, 1);
    chk("sweep_done_pulses_b", nd1, 1);

    // Abort a sweep at channel 4 by switching to continuous scan.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int t = 0; t < 20 && ch_a != 3'd4; t++) tick(1);
    chk("abort_at_ch4", int'(ch_a), 4);
    chk("abort_busy_before", int'(busy_a), 1);
    mode = 2'b01;
    tick(1);
    chk("abort_busy_a", int'(busy_a), 0);
    chk("abort_busy_b", int'(busy_b), 0);
    chk("abort_no_done_a", int'(done_a), 0);
    chk("abort_no_done_b", int'(done_b), 0);
    chk("abort_ch_hold", int'(ch_a), 4);
    tick(1);
    chk("abort_restart_ch", int'(ch_a), 0);

    // Asynchronous reset in the middle of a sweep.
    mode = 2'b10;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk("rst_busy_before", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_busy_a", int'(busy_a), 0);
      chk("idle_valid_a", int'(ov_a), 0);
      chk("idle_busy_b", int'(busy_b), 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      sett      = 3'($urandom_range(0, 7));
      start     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data      = $urandom;
      tick(1);
    end

    // Drain any pending sample.
    mode = 2'b11; start = 1'b0; out_ready = 1'b1;
    tick(4);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
